// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and FSM state type for the serial arithmetic blocks
package arith_pkg;

  // Default operand/result width shared by the serial adder/subtractor pair.
  localparam int WIDTH_DEF = 4;

  // Bit counter width for the default operand width.
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  // Serial operation sequencing: capture, one bit per cycle, completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done operand and result bundle for the serial subtractor
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  // Requester side: presents operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, d, bo, ovf
  );

  // Arithmetic unit side.
  modport slave (
    input  start, a, b,
    output busy, done, d, bo, ovf
  );

endinterface

// File: rtl/fsub_cell.sv
// rtl/fsub_cell.sv - combinational 1-bit full subtractor
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Borrow is generated when y exceeds x, or propagated when x == y.
  always_comb begin
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor D = A - B with start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   s
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             as_q, as_d;
  logic             bs_q, bs_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;

  // Single shared bit cell: consumes the current LSBs and the running borrow.
  fsub_cell u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // Difference bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
  assign res_next = {cell_diff, res_q[WIDTH-1:1]};

  // Next-state and registered-output computation; DONE also accepts a new start.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    as_d    = as_q;
    bs_d    = bs_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (s.start) begin
          sa_d    = s.a;
          sb_d    = s.b;
          as_d    = s.a[WIDTH-1];
          bs_d    = s.b[WIDTH-1];
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_next;
        br_d  = cell_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Result is published only here, so d/bo/ovf stay stable while shifting.
          d_d     = res_next;
          bo_d    = cell_bout;
          ovf_d   = (as_q != bs_q) & (cell_diff != as_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      as_q    <= as_d;
      bs_q    <= bs_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s.busy = busy_q;
  assign s.done = done_q;
  assign s.d    = d_q;
  assign s.bo   = bo_q;
  assign s.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for the serial subtractor
module tb_serial_subtractor;

  typedef struct {
    logic [3:0] d;
    logic       bo;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
    logic       ovf;
  } vec_t;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(4)) sif ();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sif)
  );

  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sbq[$];
  logic [3:0] last_d;
  logic       last_bo;
  logic       last_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction and sign rule.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [4:0] full;
    full  = {1'b0, a} - {1'b0, b};
    e.d   = full[3:0];
    e.bo  = (a < b);
    e.ovf = (a[3] != b[3]) && (e.d[3] != a[3]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation from a negedge and wait for its done pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input exp_t e);
    int lat;
    lat = 0;
    sif.a     = a;
    sif.b     = b;
    sif.start = 1'b1;
    sbq.push_back(e);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.done) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 5);
  endtask

  // Scoreboard and hold monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_d   = 4'd0;
        last_bo  = 1'b0;
        last_ovf = 1'b0;
      end else if (sif.done) begin
        done_cnt++;
        chk("busy_at_done", sif.busy, 0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 required no pending result at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("d", sif.d, e.d);
          chk("bo", sif.bo, e.bo);
          chk("ovf", sif.ovf, e.ovf);
        end
        last_d   = sif.d;
        last_bo  = sif.bo;
        last_ovf = sif.ovf;
      end else if (sif.busy) begin
        chk("hold_d", sif.d, last_d);
        chk("hold_bo", sif.bo, last_bo);
        chk("hold_ovf", sif.ovf, last_ovf);
      end
    end
  end

  initial begin
    vec_t vecs[4];
    int   dc0;
    int   n;

    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    last_d   = 4'd0;
    last_bo  = 1'b0;
    last_ovf = 1'b0;

    vecs[0] = '{a: 4'b0110, b: 4'b0011, d: 4'b0011, bo: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 4'b1011, b: 4'b0110, d: 4'b0101, bo: 1'b0, ovf: 1'b1};
    vecs[2] = '{a: 4'b0011, b: 4'b0110, d: 4'b1101, bo: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'b0000, b: 4'b0000, d: 4'b0000, bo: 1'b0, ovf: 1'b0};

    // Reset with start held high: reset must win.
    rst_n     = 1'b0;
    sif.start = 1'b1;
    sif.a     = 4'b1111;
    sif.b     = 4'b0001;
    repeat (3) @(negedge clk);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_d", sif.d, 0);
    chk("rst_bo", sif.bo, 0);
    chk("rst_ovf", sif.ovf, 0);
    sif.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle_busy", sif.busy, 0);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d   = vecs[i].d;
      e.bo  = vecs[i].bo;
      e.ovf = vecs[i].ovf;
      run_op(vecs[i].a, vecs[i].b, e);
    end
    @(negedge clk);

    // Start while busy is ignored; start in DONE is accepted back-to-back.
    #1;
    dc0       = done_cnt;
    sif.a     = 4'd9;
    sif.b     = 4'd2;
    sif.start = 1'b1;
    sbq.push_back(model(4'd9, 4'd2));
    @(negedge clk);
    sif.start = 1'b0;
    chk("busy_after_start", sif.busy, 1);
    @(negedge clk);
    sif.a     = 4'd1;
    sif.b     = 4'd7;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = 4'd0;
    sif.b     = 4'd0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sif.done) begin
        n = i;
        break;
      end
    end
    chk("ignored_start_latency", 3 + n, 5);
    run_op(4'd4, 4'd12, model(4'd4, 4'd12));
    #1;
    chk("done_pulses", done_cnt - dc0, 2);

    // Reset during the third SHIFT cycle aborts without a done.
    sif.a     = 4'd5;
    sif.b     = 4'd1;
    sif.start = 1'b1;
    sbq.push_back(model(4'd5, 4'd1));
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("abort_busy", sif.busy, 0);
    chk("abort_done", sif.done, 0);
    chk("abort_d", sif.d, 0);
    chk("abort_bo", sif.bo, 0);
    chk("abort_ovf", sif.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", sif.done, 0);
    end
    run_op(4'd7, 4'd2, model(4'd7, 4'd2));

    // Exhaustive sweep, issued back-to-back from each DONE cycle.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      run_op(ab[7:4], ab[3:0], model(ab[7:4], ab[3:0]));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
